keypad_scanner: RTL and testbench

- Upstream input stage of the calculator datapath. Scans a 4x4 matrix keypad and debounces each press.
- Emits a 4-bit key code on `tecla` with a single-cycle `ready` strobe, in the form the operation/state-machine stage consumes.
- That stage samples on the negedge of `Clock`. This block drives all outputs from posedge flops, so every strobe is stable across exactly one negedge.

---
 rtl/keypad_scanner.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-cycle ready strobe.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DWELL      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_RATE     = 100000
) (
  input  logic       Clock,
  input  logic       clearN,
  input  logic [3:0] rowIn,
  output logic [3:0] colOut,
  output logic [3:0] tecla,
  output logic       ready,
  output logic       held
);

  localparam int unsigned DWELL_W = $clog2(SCAN_DWELL);
  localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Elaboration-time parameter sanity checks
  if (SCAN_DWELL < 4) begin : g_dwell_chk
    $error("SCAN_DWELL must be >= 4");
  end
  if (REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_repeat_chk
    $error("REPEAT_DELAY and REPEAT_RATE must be >= 2");
  end

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    PRESS,
    HELD,
    RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           col_q, col_d;
  logic [1:0]           row_q, row_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DEB_W-1:0]     deb_q, deb_d;
  logic [3:0]           row_meta, row_sync;
  logic [3:0]           col_out_d, tecla_d;
  logic                 ready_d, held_d;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_first_q, rep_first_d;
  logic [REP_W-1:0] rep_target_c;

  assign rep_target_c = rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
`endif

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hC;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hD;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hA;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Registers: synchronizer, FSM state, counters and outputs
  always_ff @(posedge Clock or negedge clearN) begin
    if (!clearN) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      state_q  <= SCAN;
      col_q    <= 2'd0;
      row_q    <= 2'd0;
      dwell_q  <= '0;
      deb_q    <= '0;
      colOut   <= 4'b1110;
      tecla    <= 4'h0;
      ready    <= 1'b0;
      held     <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q       <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      row_meta <= rowIn;
      row_sync <= row_meta;
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      dwell_q  <= dwell_d;
      deb_q    <= deb_d;
      colOut   <= col_out_d;
      tecla    <= tecla_d;
      ready    <= ready_d;
      held     <= held_d;
`ifdef KEY_REPEAT_EN
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    deb_d   = deb_q;
    tecla_d = tecla;
    ready_d = 1'b0;
    held_d  = held;
`ifdef KEY_REPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_W'(SCAN_DWELL - 1)) begin
          dwell_d = '0;
          if (row_sync != 4'hF) begin
            if (!row_sync[0])      row_d = 2'd0;
            else if (!row_sync[1]) row_d = 2'd1;
            else if (!row_sync[2]) row_d = 2'd2;
            else                   row_d = 2'd3;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end

      DEBOUNCE: begin
        if (row_sync[row_q]) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d = PRESS;
          tecla_d = key_code(row_q, col_q);
          ready_d = 1'b1;
          held_d  = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_d       = '0;
          rep_first_d = 1'b1;
`endif
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      PRESS: begin
        state_d = HELD;
`ifdef KEY_REPEAT_EN
        rep_d = rep_q + REP_W'(1);
`endif
      end

      HELD: begin
        if (row_sync[row_q]) begin
          state_d = RELEASE;
          deb_d   = '0;
`ifdef KEY_REPEAT_EN
          rep_d = '0;
        end else if (rep_q + REP_W'(1) == rep_target_c) begin
          ready_d     = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_d = rep_q + REP_W'(1);
`endif
        end
      end

      RELEASE: begin
        if (!row_sync[row_q]) begin
          state_d = HELD;
`ifdef KEY_REPEAT_EN
          rep_d       = '0;
          rep_first_d = 1'b1;
`endif
        end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d = SCAN;
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      default: state_d = SCAN;
    endcase

    col_out_d = ~(4'b0001 << col_d);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, randomized presses,
// timing windows and key codes derived from the keypad rules.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DWELL = 4;
  localparam int unsigned DEB        = 8;
  localparam int unsigned RD         = 32;
  localparam int unsigned RR         = 16;
  localparam int          LAT_MAX    = 4 * SCAN_DWELL + 2 + DEB;

  logic       Clock = 1'b0;
  logic       clearN;
  logic [3:0] rowIn, colOut, tecla;
  logic       ready, held;
  logic [15:0] keys;

  keypad_scanner #(
    .SCAN_DWELL(SCAN_DWELL),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .Clock(Clock),
    .clearN(clearN),
    .rowIn(rowIn),
    .colOut(colOut),
    .tecla(tecla),
    .ready(ready),
    .held(held)
  );

  always #5 Clock = ~Clock;

  // Passive matrix: a pressed key shorts its row to its column when that column is driven low
  always_comb begin
    rowIn = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !colOut[c]) rowIn[r] = 1'b0;
  end

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hC,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hD,
                              4'hE, 4'h0, 4'hF, 4'hA};

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int back_to_back = 0;
  logic prev_ready = 1'b0;
  int         pulse_cyc[$];
  logic [3:0] pulse_code[$];

  // Strobe recorder
  always @(posedge Clock) begin
    cyc++;
    #1;
    if (ready === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_code.push_back(tecla);
      if (prev_ready === 1'b1) back_to_back++;
    end
    prev_ready = ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  function automatic logic [3:0] code_at(input int i);
    return (i < pulse_code.size()) ? pulse_code[i] : 4'bxxxx;
  endfunction

  task automatic do_press(input int r, input int c, output int lat, output int idx);
    idx = pulse_cyc.size();
    step(int'($urandom_range(0, 15)));
    keys[r*4+c] = 1'b1;
    lat = -1;
    for (int i = 1; i <= LAT_MAX + 4; i++) begin
      step(1);
      if (pulse_cyc.size() > idx) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    clearN = 1'b0;
    keys   = '0;
    step(2);
    total++; if (colOut !== 4'b1110) $display("FAIL reset_col got=%b exp=1110", colOut); else passed++;
    total++; if (tecla !== 4'h0) $display("FAIL reset_tecla got=%h exp=0", tecla); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else passed++;
    total++; if (held !== 1'b0) $display("FAIL reset_held got=%b exp=0", held); else passed++;
    clearN = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      exp_col = ~(4'b0001 << ((k / SCAN_DWELL) % 4));
      total++;
      if (colOut !== exp_col) $display("FAIL scan_col k=%0d got=%b exp=%b", k, colOut, exp_col);
      else passed++;
    end
    step(2);
    #3;
    clearN = 1'b0;
    #1;
    total++; if (colOut !== 4'b1110) $display("FAIL midscan_reset_col got=%b exp=1110", colOut); else passed++;
    total++; if (tecla !== 4'h0) $display("FAIL midscan_reset_tecla got=%h exp=0", tecla); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL midscan_reset_ready got=%b exp=0", ready); else passed++;
    total++; if (held !== 1'b0) $display("FAIL midscan_reset_held got=%b exp=0", held); else passed++;
    step(2);
    clearN = 1'b1;
    step(3);
  endtask

  task automatic test_clean_press();
    int lat, idx;
    do_press(1, 2, lat, idx);
    total++;
    if (lat < int'(DEB) || lat > LAT_MAX) $display("FAIL clean_latency got=%0d exp=%0d..%0d", lat, DEB, LAT_MAX);
    else passed++;
    total++;
    if (code_at(idx) !== keymap[6]) $display("FAIL clean_code got=%h exp=%h", code_at(idx), keymap[6]);
    else passed++;
    step(200 - ((lat > 0) ? lat : 0));
    total++; if (held !== 1'b1) $display("FAIL clean_held_down got=%b exp=1", held); else passed++;
    keys = '0;
    step(DEB);
    total++; if (held !== 1'b1) $display("FAIL clean_held_release_min got=%b exp=1", held); else passed++;
    step(4);
    total++; if (held !== 1'b0) $display("FAIL clean_held_cleared got=%b exp=0", held); else passed++;
`ifdef KEY_REPEAT_EN
    total++;
    if (pulse_cyc.size() - idx < 2) $display("FAIL clean_repeat_count got=%0d exp>=2", pulse_cyc.size() - idx);
    else passed++;
`else
    total++;
    if (pulse_cyc.size() - idx !== 1) $display("FAIL clean_pulse_count got=%0d exp=1", pulse_cyc.size() - idx);
    else passed++;
`endif
    step(10);
  endtask

  task automatic test_bounce();
    int idx, lat;
    idx = pulse_cyc.size();
    keys[3] = 1'b1;
    repeat (10) begin
      step(3);
      keys[3] = ~keys[3];
    end
    total++;
    if (pulse_cyc.size() !== idx) $display("FAIL bounce_no_early got=%0d exp=0", pulse_cyc.size() - idx);
    else passed++;
    lat = -1;
    for (int i = 1; i <= LAT_MAX + 4; i++) begin
      step(1);
      if (pulse_cyc.size() > idx) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat < 0 || lat > LAT_MAX) $display("FAIL bounce_latency got=%0d exp<=%0d", lat, LAT_MAX);
    else passed++;
    total++;
    if (code_at(idx) !== keymap[3]) $display("FAIL bounce_code got=%h exp=%h", code_at(idx), keymap[3]);
    else passed++;
    step(20);
    keys[3] = 1'b0;
    repeat (4) begin
      step(3);
      keys[3] = ~keys[3];
    end
    step(25);
    total++;
    if (pulse_cyc.size() - idx !== 1) $display("FAIL bounce_pulse_count got=%0d exp=1", pulse_cyc.size() - idx);
    else passed++;
    total++; if (held !== 1'b0) $display("FAIL bounce_held_cleared got=%b exp=0", held); else passed++;
    step(5);
  endtask

  task automatic test_two_keys();
    int idx, lat, found;
    do_press(2, 3, lat, idx);
    total++;
    if (code_at(idx) !== keymap[11]) $display("FAIL two_first_code got=%h exp=%h", code_at(idx), keymap[11]);
    else passed++;
    step(5);
    keys[13] = 1'b1;
    step(20);
    total++;
    if (pulse_cyc.size() - idx !== 1) $display("FAIL two_no_second got=%0d exp=1", pulse_cyc.size() - idx);
    else passed++;
    keys[11] = 1'b0;
    found = 0;
    for (int i = 1; i <= 80; i++) begin
      step(1);
      if (pulse_cyc.size() > idx + 1) begin
        found = 1;
        break;
      end
    end
    total++; if (found !== 1) $display("FAIL two_second_found got=%0d exp=1", found); else passed++;
    total++;
    if (code_at(idx + 1) !== keymap[13]) $display("FAIL two_second_code got=%h exp=%h", code_at(idx + 1), keymap[13]);
    else passed++;
    step(3);
    total++; if (tecla !== keymap[13]) $display("FAIL two_tecla_port got=%h exp=%h", tecla, keymap[13]); else passed++;
    keys = '0;
    step(20);
    total++; if (held !== 1'b0) $display("FAIL two_held_cleared got=%b exp=0", held); else passed++;
    step(5);
  endtask

  task automatic test_reset_in_held();
    int r, c, idx, lat, n1;
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    do_press(r, c, lat, idx);
    step(5);
    total++; if (held !== 1'b1) $display("FAIL rih_held_before got=%b exp=1", held); else passed++;
    n1 = pulse_cyc.size();
    #3;
    clearN = 1'b0;
    #1;
    total++; if (tecla !== 4'h0) $display("FAIL rih_tecla got=%h exp=0", tecla); else passed++;
    total++; if (held !== 1'b0) $display("FAIL rih_held got=%b exp=0", held); else passed++;
    total++; if (colOut !== 4'b1110) $display("FAIL rih_col got=%b exp=1110", colOut); else passed++;
    step(2);
    total++;
    if (pulse_cyc.size() !== n1) $display("FAIL rih_no_strobe got=%0d exp=0", pulse_cyc.size() - n1);
    else passed++;
    clearN = 1'b1;
    lat = -1;
    for (int i = 1; i <= LAT_MAX + 4; i++) begin
      step(1);
      if (pulse_cyc.size() > n1) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat < int'(DEB) || lat > LAT_MAX) $display("FAIL rih_latency got=%0d exp=%0d..%0d", lat, DEB, LAT_MAX);
    else passed++;
    total++;
    if (code_at(n1) !== keymap[r*4+c]) $display("FAIL rih_code got=%h exp=%h", code_at(n1), keymap[r*4+c]);
    else passed++;
    keys = '0;
    step(20);
  endtask

  task automatic test_random_presses();
    int r, c, idx, lat;
    for (int it = 0; it < 8; it++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      do_press(r, c, lat, idx);
      total++;
      if (lat < int'(DEB) || lat > LAT_MAX)
        $display("FAIL rand_latency it=%0d key=(%0d,%0d) got=%0d exp=%0d..%0d", it, r, c, lat, DEB, LAT_MAX);
      else passed++;
      total++;
      if (code_at(idx) !== keymap[r*4+c])
        $display("FAIL rand_code it=%0d key=(%0d,%0d) got=%h exp=%h", it, r, c, code_at(idx), keymap[r*4+c]);
      else passed++;
      step(int'($urandom_range(5, 25)));
      keys = '0;
      step(DEB);
      total++; if (held !== 1'b1) $display("FAIL rand_held_min it=%0d got=%b exp=1", it, held); else passed++;
      step(4);
      total++; if (held !== 1'b0) $display("FAIL rand_held_clear it=%0d got=%b exp=0", it, held); else passed++;
      total++;
      if (pulse_cyc.size() - idx !== 1)
        $display("FAIL rand_count it=%0d got=%0d exp=1", it, pulse_cyc.size() - idx);
      else passed++;
      step(10);
    end
  endtask

  task automatic test_hold_strobes();
    int idx, lat, t0, bad;
    do_press(3, 0, lat, idx);
    t0 = (idx < pulse_cyc.size()) ? pulse_cyc[idx] : 0;
    total++;
    if (code_at(idx) !== keymap[12]) $display("FAIL hold_first_code got=%h exp=%h", code_at(idx), keymap[12]);
    else passed++;
    step(100);
    keys = '0;
    step(20);
`ifdef KEY_REPEAT_EN
    total++;
    if (pulse_cyc.size() - idx !== 6) $display("FAIL repeat_count got=%0d exp=6", pulse_cyc.size() - idx);
    else passed++;
    for (int k = 1; k <= 5; k++) begin
      total++;
      if (idx + k >= pulse_cyc.size())
        $display("FAIL repeat_time k=%0d got=missing exp=%0d", k, RD + RR * (k - 1));
      else if (pulse_cyc[idx+k] - t0 !== int'(RD + RR * (k - 1)))
        $display("FAIL repeat_time k=%0d got=%0d exp=%0d", k, pulse_cyc[idx+k] - t0, RD + RR * (k - 1));
      else passed++;
    end
    bad = 0;
    for (int k = idx; k < pulse_code.size(); k++)
      if (pulse_code[k] !== keymap[12]) bad++;
    total++; if (bad !== 0) $display("FAIL repeat_codes got=%0d_wrong exp=0", bad); else passed++;
`else
    bad = t0;
    total++;
    if (pulse_cyc.size() - idx !== 1) $display("FAIL single_strobe_count got=%0d exp=1", pulse_cyc.size() - idx);
    else passed++;
`endif
    total++; if (tecla !== keymap[12]) $display("FAIL hold_tecla_kept got=%h exp=%h", tecla, keymap[12]); else passed++;
    step(5);
  endtask

  initial begin
    clearN = 1'b0;
    keys   = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_reset_in_held();
    test_random_presses();
    test_hold_strobes();
    total++;
    if (back_to_back !== 0) $display("FAIL ready_back_to_back got=%0d exp=0", back_to_back);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
